// File: rtl/vga_sync_detect.sv
// vga_sync_detect: measures HSYNC/VSYNC timing (totals, sync widths, polarities)
// on the pixel clock and reports LOCKED once consecutive frames measure alike.
// Optional feature macro: VGA_SYNC_DETECT_FILTER_EN adds a 3-sample majority
// filter on both sync inputs, rejecting single-cycle glitches (+2 cycles latency).
module vga_sync_detect #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HSYNC_IN,
    input  logic        VSYNC_IN,
    output logic [11:0] H_TOTAL,
    output logic [7:0]  H_SYNC,
    output logic        H_POL,
    output logic [11:0] V_TOTAL,
    output logic [7:0]  V_SYNC,
    output logic        V_POL,
    output logic        MEAS_STB,
    output logic        LOCKED
);
    localparam logic [11:0] CNT_MAX = 12'hFFF;
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[7:0];
    endfunction

    logic hs_in_s, vs_in_s;
    logic hs_q, vs_q, hs_prev_q, vs_prev_q;

    // Register the sync levels and keep a one-cycle-delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            hs_q      <= hs_in_s;
            vs_q      <= vs_in_s;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
        end
    end

`ifdef VGA_SYNC_DETECT_FILTER_EN
    logic [2:0] hs_sh_q, vs_sh_q;

    assign hs_in_s = (hs_sh_q[0] & hs_sh_q[1]) | (hs_sh_q[0] & hs_sh_q[2]) | (hs_sh_q[1] & hs_sh_q[2]);
    assign vs_in_s = (vs_sh_q[0] & vs_sh_q[1]) | (vs_sh_q[0] & vs_sh_q[2]) | (vs_sh_q[1] & vs_sh_q[2]);

    // Raw input samples feeding the majority vote; bit 0 is the newest.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hs_sh_q <= 3'b000;
            vs_sh_q <= 3'b000;
        end else begin
            hs_sh_q <= {hs_sh_q[1:0], HSYNC_IN};
            vs_sh_q <= {vs_sh_q[1:0], VSYNC_IN};
        end
    end
`else
    assign hs_in_s = HSYNC_IN;
    assign vs_in_s = VSYNC_IN;
`endif

    logic hs_rise, hs_tgl, vs_rise;
    assign hs_rise = hs_q & ~hs_prev_q;
    assign hs_tgl  = hs_q ^ hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;

    // ph_cnt_q counts cycles of the current HSYNC level; at a rising edge it holds
    // the just-finished low phase, so no separate low-length register is needed.
    logic [11:0] ph_cnt_q, ph_cnt_d, hi_len_q, hi_len_d;
    logic [11:0] ln_total_q, ln_total_d;
    logic [7:0]  ln_sync_q, ln_sync_d;
    logic        ln_pol_q, ln_pol_d;
    logic        unstable_q, unstable_d;
    logic [11:0] vhi_q, vhi_d, vlo_q, vlo_d;

    logic [12:0] line_sum, frame_sum;
    logic [11:0] line_len, line_min, frame_len, frame_min;
    assign line_sum  = {1'b0, hi_len_q} + {1'b0, ph_cnt_q};
    assign line_len  = line_sum[12] ? CNT_MAX : line_sum[11:0];
    assign line_min  = (hi_len_q <= ph_cnt_q) ? hi_len_q : ph_cnt_q;
    assign frame_sum = {1'b0, vhi_q} + {1'b0, vlo_q};
    assign frame_len = frame_sum[12] ? CNT_MAX : frame_sum[11:0];
    assign frame_min = (vhi_q <= vlo_q) ? vhi_q : vlo_q;

    state_e state_q, state_d;
    logic   timeout, load, meas_match;
    assign timeout = (ph_cnt_q == CNT_MAX) | (vhi_q == CNT_MAX) | (vlo_q == CNT_MAX);
    assign load    = vs_rise & (state_q != IDLE) & ~timeout;

    logic [11:0] h_total_q, v_total_q;
    logic [7:0]  h_sync_q, v_sync_q;
    logic        h_pol_q, v_pol_q, meas_stb_q;

    assign meas_match = (ln_total_q == h_total_q) && (ln_sync_q == h_sync_q) &&
                        (ln_pol_q == h_pol_q) && (frame_len == v_total_q) &&
                        (sat8(frame_min) == v_sync_q) && ((vhi_q <= vlo_q) == v_pol_q);

    // Next-state for the phase/line counters, per-line measurement and stability flag.
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        ph_cnt_d   = hs_tgl ? 12'd1 : sat_inc(ph_cnt_q);
        hi_len_d   = hi_len_q;
        ln_total_d = ln_total_q;
        ln_sync_d  = ln_sync_q;
        ln_pol_d   = ln_pol_q;
        unstable_d = unstable_q;
        vhi_d      = vhi_q;
        vlo_d      = vlo_q;

        if (hs_tgl && !hs_q) hi_len_d = ph_cnt_q;
        if (hs_rise) begin
            ln_total_d = line_len;
            ln_sync_d  = sat8(line_min);
            ln_pol_d   = (hi_len_q <= ph_cnt_q);
        end

        // The frame closes before a coincident HSYNC edge, which opens the new frame.
        if (vs_rise) unstable_d = 1'b0;
        if (hs_rise && (line_len != ln_total_q)) unstable_d = 1'b1;

        if (vs_rise) begin
            vhi_d = {11'd0, hs_rise};
            vlo_d = 12'd0;
        end else if (hs_rise) begin
            if (vs_q) vhi_d = sat_inc(vhi_q);
            else      vlo_d = sat_inc(vlo_q);
        end
    end

    // Measurement registers and output latches loaded at frame end.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ph_cnt_q   <= 12'd0;
            hi_len_q   <= 12'd0;
            ln_total_q <= 12'd0;
            ln_sync_q  <= 8'd0;
            ln_pol_q   <= 1'b0;
            unstable_q <= 1'b0;
            vhi_q      <= 12'd0;
            vlo_q      <= 12'd0;
            h_total_q  <= 12'd0;
            h_sync_q   <= 8'd0;
            h_pol_q    <= 1'b0;
            v_total_q  <= 12'd0;
            v_sync_q   <= 8'd0;
            v_pol_q    <= 1'b0;
            meas_stb_q <= 1'b0;
        end else begin
            ph_cnt_q   <= ph_cnt_d;
            hi_len_q   <= hi_len_d;
            ln_total_q <= ln_total_d;
            ln_sync_q  <= ln_sync_d;
            ln_pol_q   <= ln_pol_d;
            unstable_q <= unstable_d;
            vhi_q      <= vhi_d;
            vlo_q      <= vlo_d;
            meas_stb_q <= load;
            if (load) begin
                h_total_q <= ln_total_q;
                h_sync_q  <= ln_sync_q;
                h_pol_q   <= ln_pol_q;
                v_total_q <= frame_len;
                v_sync_q  <= sat8(frame_min);
                v_pol_q   <= (vhi_q <= vlo_q);
            end
        end
    end

    logic [3:0] match_cnt_q, match_cnt_d;
    logic       first_q, first_d;

    // Lock FSM next-state: timeout dominates, the first frame after arm is only stored.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        first_d     = first_q;
        if (timeout) begin
            state_d     = IDLE;
            match_cnt_d = 4'd0;
            first_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (vs_rise) begin
                    state_d     = ACQ;
                    match_cnt_d = 4'd0;
                    first_d     = 1'b1;
                end
                ACQ: if (load) begin
                    if (first_q) begin
                        first_d     = 1'b0;
                        match_cnt_d = 4'd0;
                    end else if (meas_match && !unstable_q) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_N) state_d = LOCK;
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end
                LOCK: if (load && (!meas_match || unstable_q)) begin
                    state_d     = ACQ;
                    match_cnt_d = 4'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            match_cnt_q <= 4'd0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            first_q     <= first_d;
        end
    end

    assign H_TOTAL  = h_total_q;
    assign H_SYNC   = h_sync_q;
    assign H_POL    = h_pol_q;
    assign V_TOTAL  = v_total_q;
    assign V_SYNC   = v_sync_q;
    assign V_POL    = v_pol_q;
    assign MEAS_STB = meas_stb_q;
    assign LOCKED   = (state_q == LOCK);
endmodule
